// File: rtl/usb2_fx2_fifo_model.sv
// ----------------------------------------------------------------------------
// usb2_fx2_fifo_model
//
// Simulation model of an FX2-style synchronous slave FIFO. It sits on the
// testbench side of a USB FIFO interface and plays the role of the USB chip:
//   - EP2 (OUT, host->FPGA): a pattern generator (MODE 0) or the EP6 FIFO
//     looped back (MODE 1), read through usb_fd with SLRD/SLOE.
//   - EP6 (IN, FPGA->host): a DEPTH-word circular FIFO written with SLWR. In
//     MODE 0 a host drain pops one word every DRAIN_DIV cycles and compares it
//     against the expected pattern.
//
// Ports
//   usb_clk                 interface clock, all state on its rising edge
//   rst                     asynchronous active-high reset
//   usb_fifoaddr[1:0]       endpoint select: 00 = EP2, 10 = EP6
//   usb_slcs/sloe/slrd/slwr active-low chip select / output enable / strobes
//   usb_fd[DW-1:0]          bidirectional data bus (driven only for EP2 reads)
//   usb_flaga               EP2 data available
//   usb_flagb               EP6 full
//   usb_flagc               EP6 level >= PF_LEVEL
//   usb_download_finished   MODE 0: all OUT_WORDS generated words consumed
//   rx_words[15:0]          accepted EP6 writes, saturating
//   err_underrun            sticky: EP2 read while usb_flaga = 0
//   err_overrun             sticky: EP6 write while usb_flagb = 1
//   err_mismatch            sticky: drained EP6 word differed from pattern
// ----------------------------------------------------------------------------
module usb2_fx2_fifo_model #(
    parameter int unsigned DW        = 16,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned OUT_WORDS = 256,
    parameter logic [15:0] PAT_START = 16'h0100,
    parameter logic [15:0] PAT_INC   = 16'h0202,
    parameter int unsigned PF_LEVEL  = 384,
    parameter int unsigned MODE      = 0,
    parameter int unsigned DRAIN_DIV = 4
) (
    input  logic          usb_clk,
    input  logic          rst,
    input  logic [1:0]    usb_fifoaddr,
    input  logic          usb_slcs,
    input  logic          usb_sloe,
    input  logic          usb_slrd,
    input  logic          usb_slwr,
    inout  wire  [DW-1:0] usb_fd,
    output logic          usb_flaga,
    output logic          usb_flagb,
    output logic          usb_flagc,
    output logic          usb_download_finished,
    output logic [15:0]   rx_words,
    output logic          err_underrun,
    output logic          err_overrun,
    output logic          err_mismatch
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned LW       = AW + 1;
    localparam logic [DW-1:0] START_W = DW'(PAT_START);
    localparam logic [DW-1:0] INC_W   = DW'(PAT_INC);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] PF_L    = LW'(PF_LEVEL);
    localparam logic [15:0]   OUT_W16 = 16'(OUT_WORDS);
    localparam bit LOOPBACK = (MODE == 1);
    localparam bit DRAIN_EN = (MODE == 0) && (DRAIN_DIV > 0);
    localparam int unsigned DIVW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = (DRAIN_DIV > 0) ? DIVW'(DRAIN_DIV - 1) : '0;

    // ------------------------------------------------------------------------
    // Bus qualifiers
    // ------------------------------------------------------------------------
    logic sel2, sel6, rd, wr;
    assign sel2 = !usb_slcs && (usb_fifoaddr == 2'b00);
    assign sel6 = !usb_slcs && (usb_fifoaddr == 2'b10);
    assign rd   = sel2 && !usb_slrd;
    assign wr   = sel6 && !usb_slwr;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DW-1:0]   gen_q, gen_d;
    logic [15:0]     gcnt_q, gcnt_d;
    logic [DW-1:0]   chk_q, chk_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [15:0]     rx_q, rx_d;
    logic            unr_q, unr_d;
    logic            ovr_q, ovr_d;
    logic            mis_q, mis_d;
    logic [DW-1:0]   mem_q [DEPTH];

    // ------------------------------------------------------------------------
    // Derived conditions (all from registered state, so flags follow the
    // level one cycle after the edge that changed it)
    // ------------------------------------------------------------------------
    logic          fifo_empty, fifo_full, gen_avail;
    logic          push, pop, drain, gen_step;
    logic [DW-1:0] head, ep2_head;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == DEPTH_L);
    assign gen_avail  = (gcnt_q < OUT_W16);
    assign head       = mem_q[rd_ptr_q];
    assign ep2_head   = LOOPBACK ? head : gen_q;

    // Fullness and emptiness are judged on the pre-edge level, so a write at
    // full is rejected even when a pop happens in the same cycle.
    assign push     = wr && !fifo_full;
    assign drain    = DRAIN_EN && (div_q == DIV_LAST) && !fifo_empty;
    assign pop      = LOOPBACK ? (rd && !fifo_empty) : drain;
    assign gen_step = !LOOPBACK && rd && gen_avail;

    // Combinational drive so the bus releases the instant reset or the
    // select/enable terms drop.
    assign usb_fd = (sel2 && !usb_sloe && !rst) ? ep2_head : {DW{1'bz}};

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it
        // unassigned; that is what keeps this block free of latches.
        gen_d    = gen_q;
        gcnt_d   = gcnt_q;
        chk_d    = chk_q;
        div_d    = div_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rx_d     = rx_q;
        unr_d    = unr_q;
        ovr_d    = ovr_q;
        mis_d    = mis_q;

        if (gen_step) begin
            gen_d  = gen_q + INC_W;
            gcnt_d = gcnt_q + 16'd1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (push && (rx_q != 16'hFFFF)) begin
            rx_d = rx_q + 16'd1;
        end

        if (rd && !usb_flaga) begin
            unr_d = 1'b1;
        end
        if (wr && fifo_full) begin
            ovr_d = 1'b1;
        end

        if (drain) begin
            chk_d = chk_q + INC_W;
            if (head != chk_q) begin
                mis_d = 1'b1;
            end
        end

        if (DRAIN_EN) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIVW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            gen_q    <= START_W;
            gcnt_q   <= '0;
            chk_q    <= START_W;
            div_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rx_q     <= '0;
            unr_q    <= 1'b0;
            ovr_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            gen_q    <= gen_d;
            gcnt_q   <= gcnt_d;
            chk_q    <= chk_d;
            div_q    <= div_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rx_q     <= rx_d;
            unr_q    <= unr_d;
            ovr_q    <= ovr_d;
            mis_q    <= mis_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and level define
    // which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge usb_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= usb_fd;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign usb_flaga             = LOOPBACK ? !fifo_empty : gen_avail;
    assign usb_flagb             = fifo_full;
    assign usb_flagc             = (level_q >= PF_L);
    assign usb_download_finished = !LOOPBACK && (gcnt_q == OUT_W16);
    assign rx_words              = rx_q;
    assign err_underrun          = unr_q;
    assign err_overrun           = ovr_q;
    assign err_mismatch          = mis_q;

endmodule

// File: tb/tb_usb2_fx2_fifo_model.sv
// ----------------------------------------------------------------------------
// tb_usb2_fx2_fifo_model
//
// Four instances share clock and reset, each with its own strobes and bus:
//   u0  defaults (MODE 0, DRAIN_DIV 4): pattern read, streaming, mismatch
//   u1  MODE 0, DRAIN_DIV 0: EP6 fill, flags, overrun, mid-stream reset
//   u2  MODE 1: loopback, unused endpoints
//   u3  MODE 0, DEPTH 4, PF_LEVEL 3: cycle-exact vector table covering
//       simultaneous push/drain and a write rejected at full during a drain
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (registered state) or 1 ns after an input change (combinational bus).
// ----------------------------------------------------------------------------
module tb_usb2_fx2_fifo_model;

    logic usb_clk = 1'b0;
    logic rst     = 1'b1;
    always #5 usb_clk = ~usb_clk;

    logic [1:0]  addr  [4];
    logic        slcs  [4];
    logic        sloe  [4];
    logic        slrd  [4];
    logic        slwr  [4];
    logic        tb_en [4];
    logic [15:0] tb_d  [4];

    logic        flaga [4];
    logic        flagb [4];
    logic        flagc [4];
    logic        dlf   [4];
    logic        unr   [4];
    logic        ovr   [4];
    logic        mis   [4];
    logic [15:0] rxw   [4];

    wire [15:0] fd0, fd1, fd2, fd3;
    assign fd0 = tb_en[0] ? tb_d[0] : 16'hzzzz;
    assign fd1 = tb_en[1] ? tb_d[1] : 16'hzzzz;
    assign fd2 = tb_en[2] ? tb_d[2] : 16'hzzzz;
    assign fd3 = tb_en[3] ? tb_d[3] : 16'hzzzz;

    usb2_fx2_fifo_model u0 (
        .usb_clk(usb_clk), .rst(rst), .usb_fifoaddr(addr[0]),
        .usb_slcs(slcs[0]), .usb_sloe(sloe[0]), .usb_slrd(slrd[0]), .usb_slwr(slwr[0]),
        .usb_fd(fd0), .usb_flaga(flaga[0]), .usb_flagb(flagb[0]), .usb_flagc(flagc[0]),
        .usb_download_finished(dlf[0]), .rx_words(rxw[0]),
        .err_underrun(unr[0]), .err_overrun(ovr[0]), .err_mismatch(mis[0])
    );

    usb2_fx2_fifo_model #(.DRAIN_DIV(0)) u1 (
        .usb_clk(usb_clk), .rst(rst), .usb_fifoaddr(addr[1]),
        .usb_slcs(slcs[1]), .usb_sloe(sloe[1]), .usb_slrd(slrd[1]), .usb_slwr(slwr[1]),
        .usb_fd(fd1), .usb_flaga(flaga[1]), .usb_flagb(flagb[1]), .usb_flagc(flagc[1]),
        .usb_download_finished(dlf[1]), .rx_words(rxw[1]),
        .err_underrun(unr[1]), .err_overrun(ovr[1]), .err_mismatch(mis[1])
    );

    usb2_fx2_fifo_model #(.MODE(1)) u2 (
        .usb_clk(usb_clk), .rst(rst), .usb_fifoaddr(addr[2]),
        .usb_slcs(slcs[2]), .usb_sloe(sloe[2]), .usb_slrd(slrd[2]), .usb_slwr(slwr[2]),
        .usb_fd(fd2), .usb_flaga(flaga[2]), .usb_flagb(flagb[2]), .usb_flagc(flagc[2]),
        .usb_download_finished(dlf[2]), .rx_words(rxw[2]),
        .err_underrun(unr[2]), .err_overrun(ovr[2]), .err_mismatch(mis[2])
    );

    usb2_fx2_fifo_model #(.DEPTH(4), .PF_LEVEL(3)) u3 (
        .usb_clk(usb_clk), .rst(rst), .usb_fifoaddr(addr[3]),
        .usb_slcs(slcs[3]), .usb_sloe(sloe[3]), .usb_slrd(slrd[3]), .usb_slwr(slwr[3]),
        .usb_fd(fd3), .usb_flaga(flaga[3]), .usb_flagb(flagb[3]), .usb_flagc(flagc[3]),
        .usb_download_finished(dlf[3]), .rx_words(rxw[3]),
        .err_underrun(unr[3]), .err_overrun(ovr[3]), .err_mismatch(mis[3])
    );

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] get_fd(input int u);
        case (u)
            0:       return fd0;
            1:       return fd1;
            2:       return fd2;
            default: return fd3;
        endcase
    endfunction

    // {flaga, flagb, flagc, download_finished, underrun, overrun, mismatch}
    function automatic logic [6:0] flags(input int u);
        return {flaga[u], flagb[u], flagc[u], dlf[u], unr[u], ovr[u], mis[u]};
    endfunction

    task automatic set_idle(input int u);
        addr[u]  = 2'b00;
        slcs[u]  = 1'b1;
        sloe[u]  = 1'b1;
        slrd[u]  = 1'b1;
        slwr[u]  = 1'b1;
        tb_en[u] = 1'b0;
        tb_d[u]  = 16'h0000;
    endtask

    task automatic set_read(input int u);
        set_idle(u);
        slcs[u] = 1'b0;
        sloe[u] = 1'b0;
        slrd[u] = 1'b0;
    endtask

    task automatic set_write(input int u, input logic [15:0] d);
        set_idle(u);
        addr[u]  = 2'b10;
        slcs[u]  = 1'b0;
        slwr[u]  = 1'b0;
        tb_en[u] = 1'b1;
        tb_d[u]  = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge usb_clk);
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Cycle-exact vectors for u3 (DEPTH 4, PF_LEVEL 3, drain at edges 4,8,..)
    // ------------------------------------------------------------------------
    typedef struct {
        logic        wr;
        logic [15:0] din;
        logic        fb;
        logic        fc;
        logic        ov;
        logic        mis;
        logic [15:0] rx;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [15:0] d,
                                input logic b, input logic c, input logic o,
                                input logic m, input logic [15:0] r);
        vec_t v;
        v.wr = w; v.din = d; v.fb = b; v.fc = c; v.ov = o; v.mis = m; v.rx = r;
        return v;
    endfunction

    vec_t vec [24];

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    logic [15:0] exp_w;
    logic [6:0]  fl;
    int          n_wr;
    int          cyc;
    logic        saw_full;

    initial begin
        // Level-by-level expectations: p0..p5 = 0100,0302,0504,0706,0908,0B0A.
        vec[0]  = mk(1'b1, 16'h0100, 0, 0, 0, 0, 16'd1);  // L1
        vec[1]  = mk(1'b1, 16'h0302, 0, 0, 0, 0, 16'd2);  // L2
        vec[2]  = mk(1'b1, 16'h0504, 0, 1, 0, 0, 16'd3);  // L3 reaches PF
        vec[3]  = mk(1'b1, 16'h0706, 0, 1, 0, 0, 16'd4);  // push + drain, L3
        vec[4]  = mk(1'b1, 16'h0908, 1, 1, 0, 0, 16'd5);  // L4 full
        vec[5]  = mk(1'b0, 16'h0000, 1, 1, 0, 0, 16'd5);
        vec[6]  = mk(1'b0, 16'h0000, 1, 1, 0, 0, 16'd5);
        vec[7]  = mk(1'b1, 16'h0B0A, 0, 1, 1, 0, 16'd5);  // write at full + drain
        vec[8]  = mk(1'b0, 16'h0000, 0, 1, 1, 0, 16'd5);
        vec[9]  = mk(1'b0, 16'h0000, 0, 1, 1, 0, 16'd5);
        vec[10] = mk(1'b0, 16'h0000, 0, 1, 1, 0, 16'd5);
        vec[11] = mk(1'b0, 16'h0000, 0, 0, 1, 0, 16'd5);  // drain p2, L2
        vec[12] = mk(1'b1, 16'hDEAD, 0, 1, 1, 0, 16'd6);  // L3
        for (int i = 13; i < 23; i++) begin
            vec[i] = mk(1'b0, 16'h0000, 0, (i < 15) ? 1'b1 : 1'b0, 1, 0, 16'd6);
        end
        vec[23] = mk(1'b0, 16'h0000, 0, 0, 1, 1, 16'd6);  // DEAD vs p5

        for (int u = 0; u < 4; u++) set_idle(u);

        // ---------------- reset state ----------------
        do_reset();
        check("rst_flags_u0", 32'(flags(0)), 32'h40);
        check("rst_rx_u0", 32'(rxw[0]), 32'h0);
        check("rst_flags_u1", 32'(flags(1)), 32'h40);
        check("rst_flags_u2_loopback", 32'(flags(2)), 32'h00);
        check("rst_flags_u3", 32'(flags(3)), 32'h40);

        // ---------------- u0: 300 back-to-back EP2 reads ----------------
        exp_w = 16'h0100;
        for (int i = 0; i < 300; i++) begin
            set_read(0);
            #1;
            check($sformatf("pat_word[%0d]", i), 32'(get_fd(0)),
                  32'((i < 256) ? exp_w : 16'h0300));
            if (i < 256) exp_w = exp_w + 16'h0202;
            @(negedge usb_clk);
            if (i == 254) check("pat_before_last", 32'(flags(0)), 32'h40);
            if (i == 255) check("pat_finished", 32'(flags(0)), 32'h08);
            if (i == 256) check("pat_underrun", 32'(flags(0)), 32'h0C);
        end
        set_idle(0);
        check("pat_end_flags", 32'(flags(0)), 32'h0C);

        // ---------------- u1: fill EP6 without draining ----------------
        exp_w = 16'h0100;
        for (int i = 0; i < 513; i++) begin
            set_write(1, exp_w);
            exp_w = exp_w + 16'h0202;
            @(negedge usb_clk);
            if (i == 382) check("fill_l383", 32'(flags(1)), 32'h40);
            if (i == 383) check("fill_l384_pf", 32'(flags(1)), 32'h50);
            if (i == 510) check("fill_l511", 32'(flags(1)), 32'h50);
            if (i == 511) check("fill_l512_full", 32'(flags(1)), 32'h70);
            if (i == 512) check("fill_overrun", 32'(flags(1)), 32'h72);
        end
        set_idle(1);
        check("fill_rx_words", 32'(rxw[1]), 32'd512);

        // ---------------- u1: reset in the middle of a read stream ----------------
        set_read(1);
        repeat (3) @(negedge usb_clk);
        #1;
        check("rst_mid_bus_before", 32'(get_fd(1)), 32'h0706);
        #1;
        tb_d[1]  = 16'h0000;
        tb_en[1] = 1'b1;
        rst      = 1'b1;
        #1;
        check("rst_mid_bus_released", 32'(get_fd(1)), 32'h0000);
        check("rst_mid_flags", 32'(flags(1)), 32'h40);
        check("rst_mid_rx", 32'(rxw[1]), 32'h0);
        @(negedge usb_clk);
        rst      = 1'b0;
        tb_en[1] = 1'b0;
        #1;
        check("rst_mid_first_word", 32'(get_fd(1)), 32'h0100);
        @(negedge usb_clk);
        #1;
        check("rst_mid_second_word", 32'(get_fd(1)), 32'h0302);
        set_idle(1);

        // ---------------- u0: 1000 flow-controlled pattern writes ----------------
        do_reset();
        exp_w    = 16'h0100;
        n_wr     = 0;
        cyc      = 0;
        saw_full = 1'b0;
        while ((n_wr < 1000) && (cyc < 10000)) begin
            if (flagb[0]) begin
                saw_full = 1'b1;
                set_idle(0);
            end else begin
                set_write(0, exp_w);
                exp_w = exp_w + 16'h0202;
                n_wr++;
            end
            @(negedge usb_clk);
            cyc++;
        end
        set_idle(0);
        check("stream_within_budget", 32'(cyc < 10000), 32'h1);
        check("stream_saw_full", 32'(saw_full), 32'h1);
        check("stream_rx_words", 32'(rxw[0]), 32'd1000);
        fl = flags(0);
        check("stream_no_errors", 32'(fl[2:0]), 32'h0);
        repeat (2200) @(negedge usb_clk);
        check("stream_drained_flags", 32'(flags(0)), 32'h40);

        // ---------------- u0: corrupted 10th word ----------------
        do_reset();
        exp_w = 16'h0100;
        for (int i = 0; i < 20; i++) begin
            set_write(0, (i == 9) ? 16'hDEAD : exp_w);
            exp_w = exp_w + 16'h0202;
            @(negedge usb_clk);
        end
        set_idle(0);
        check("mis_after_writes", 32'(flags(0)), 32'h40);
        repeat (19) @(negedge usb_clk);
        check("mis_before_drain", 32'(flags(0)), 32'h40);
        @(negedge usb_clk);
        check("mis_at_drain", 32'(flags(0)), 32'h41);
        repeat (100) @(negedge usb_clk);
        check("mis_sticky", 32'(flags(0)), 32'h41);
        check("mis_rx_words", 32'(rxw[0]), 32'd20);

        // ---------------- u2: loopback ----------------
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_write(2, 16'(i + 1));
            @(negedge usb_clk);
        end
        check("lb_after_writes", 32'(flags(2)), 32'h40);
        // Unused endpoint 11 with every strobe active: no drive, no state change.
        set_idle(2);
        addr[2]  = 2'b11;
        slcs[2]  = 1'b0;
        sloe[2]  = 1'b0;
        slrd[2]  = 1'b0;
        slwr[2]  = 1'b0;
        tb_en[2] = 1'b1;
        tb_d[2]  = 16'h0000;
        #1;
        check("lb_unused_ep_no_drive", 32'(get_fd(2)), 32'h0000);
        @(negedge usb_clk);
        addr[2] = 2'b01;
        tb_d[2] = 16'hBEEF;
        @(negedge usb_clk);
        check("lb_unused_rx", 32'(rxw[2]), 32'd8);
        for (int i = 0; i < 8; i++) begin
            set_read(2);
            #1;
            check($sformatf("lb_word[%0d]", i), 32'(get_fd(2)), 32'(i + 1));
            @(negedge usb_clk);
            if (i == 6) check("lb_one_left", 32'(flags(2)), 32'h40);
        end
        check("lb_empty", 32'(flags(2)), 32'h00);
        @(negedge usb_clk);
        set_idle(2);
        check("lb_underrun", 32'(flags(2)), 32'h04);

        // ---------------- u3: cycle-exact vector table ----------------
        do_reset();
        for (int r = 0; r < 24; r++) begin
            if (vec[r].wr) set_write(3, vec[r].din);
            else           set_idle(3);
            @(negedge usb_clk);
            check($sformatf("vec_edge%0d", r + 1),
                  32'({flagb[3], flagc[3], ovr[3], mis[3], rxw[3]}),
                  32'({vec[r].fb, vec[r].fc, vec[r].ov, vec[r].mis, vec[r].rx}));
        end
        set_idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb2_fx2_fifo_model.md
# usb2_fx2_fifo_model

Parametrised simulation model of a Cypress FX2-style synchronous slave-FIFO device. It serves a host-to-FPGA OUT endpoint (EP2) and accepts an FPGA-to-host IN endpoint (EP6) on the shared `usb_fd` bus. Two modes are supported: pattern generation with checking, and loopback. It sits on the testbench side of the USB FIFO interface and drives the design's USB reader/writer logic with flags, data and error reporting.

## Interface
- `DW`, 16: `usb_fd` and FIFO word width.
- `DEPTH`, 512: EP6 FIFO depth in words; power of two, ≥4.
- `OUT_WORDS`, 256: number of EP2 words the generator supplies in pattern mode; range 1..65535.
- `PAT_START`, 16'h0100: first pattern word; truncated or zero-extended to DW.
- `PAT_INC`, 16'h0202: pattern increment per word, modulo 2^DW.
- `PF_LEVEL`, 384: EP6 programmable-full threshold in words; range 1..DEPTH.
- `MODE`, 0: 0 = pattern generate/check, 1 = loopback.
- `DRAIN_DIV`, 4: in MODE 0, the host drains one EP6 word every DRAIN_DIV cycles; 0 disables draining.

Ports:
- `usb_clk`  in  1  Interface clock. All state updates on its rising edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `usb_fifoaddr`  in  2  Endpoint select: 00 = EP2, 10 = EP6; 01 and 11 are unused endpoints.
- `usb_slcs`  in  1  Chip select, active low.
- `usb_sloe`  in  1  Output enable, active low.
- `usb_slrd`  in  1  Read strobe, active low.
- `usb_slwr`  in  1  Write strobe, active low.
- `usb_fd`  inout  DW  Data bus.
- `usb_flaga`  out  1  EP2 data available (1 = data valid).
- `usb_flagb`  out  1  EP6 full.
- `usb_flagc`  out  1  EP6 level ≥ PF_LEVEL.
- `usb_download_finished`  out  1  MODE 0: all OUT_WORDS words have been read. MODE 1: tied 0.
- `rx_words`  out  16  Count of accepted EP6 writes; saturates at 16'hFFFF.
- `err_underrun`  out  1  Sticky. Set by an EP2 read while `usb_flaga` = 0.
- `err_overrun`  out  1  Sticky. Set by an EP6 write while `usb_flagb` = 1.
- `err_mismatch`  out  1  Sticky. Set when a drained EP6 word differs from the expected pattern (MODE 0 only).

## Operation
- Qualifiers:
  - `sel2` = !usb_slcs & usb_fifoaddr == 00
  - `sel6` = !usb_slcs & usb_fifoaddr == 10
  - `rd` = sel2 & !usb_slrd
  - `wr` = sel6 & !usb_slwr
- Bus drive:
  - `usb_fd` is driven only when sel2 & !usb_sloe & !rst.
  - Otherwise it is high-Z. This is combinational, so release is immediate.
  - The value driven is the EP2 head word.
- EP2 source, MODE 0:
  - Generator register `gen` resets to PAT_START; counter `gcnt` resets to 0.
  - A `rd` with gcnt < OUT_WORDS sets gen += PAT_INC and gcnt += 1.
  - `usb_flaga` = (gcnt < OUT_WORDS). `usb_download_finished` = (gcnt == OUT_WORDS).
- EP2 source, MODE 1:
  - The EP2 head is the EP6 FIFO head.
  - `rd` pops the EP6 FIFO. `usb_flaga` = EP6 not empty.
- EP6 FIFO:
  - Circular buffer: DEPTH words, pointer width clog2(DEPTH), occupancy counter width clog2(DEPTH)+1.
  - `wr` with level < DEPTH captures `usb_fd` and increments the level.
  - `usb_flagb` = (level == DEPTH). `usb_flagc` = (level ≥ PF_LEVEL).
- Host drain (MODE 0, DRAIN_DIV > 0):
  - A divider counts 0..DRAIN_DIV-1.
  - On terminal count with level > 0, one word is popped and compared to the checker register `chk`.
  - `chk` resets to PAT_START and advances by PAT_INC on each drain.
  - A mismatch sets `err_mismatch`.
- Simultaneous push and pop in one cycle: the level is unchanged and both pointers advance. This also holds at full: when a drain coincides with a write at level == DEPTH, the write is still rejected, because fullness is evaluated before the update.
- Rejected operations:
  - A `rd` at empty changes no state except setting `err_underrun`.
  - A `wr` at full is dropped and sets `err_overrun`.
  - `rx_words` counts accepted writes only.
- Unused endpoints (01, 11): reads and writes are ignored; the bus is not driven.

## Timing
- Reset values:
  - All flags 0 except `usb_flaga` = 1 in MODE 0.
  - `usb_download_finished` = 0, `rx_words` = 0, all error bits = 0.
  - FIFO empty; `gen` = `chk` = PAT_START; divider = 0.
- Read latency:
  - The head word is valid combinationally while `sel2` & !usb_sloe.
  - The word advances on the clock edge at which `rd` is sampled. The consumer therefore samples word n at the same edge that pops it.
- Write latency: data is captured at the edge sampling `wr`. Flags reflect the new level in the following cycle (flags are derived from registered state).
- Reset asserted mid-transfer: all state clears asynchronously. Operations resume on the first edge after `rst` deasserts.

## Test plan
- MODE 0, default parameters: hold `rd` for 300 cycles with sloe low.
  - The bus shows 0x0100, 0x0302, 0x0504 ... for 256 words.
  - `usb_download_finished` rises after the 256th read and `usb_flaga` falls.
  - 44 further reads set `err_underrun`; `gen` does not advance.
- MODE 0, DRAIN_DIV = 0: write 512 pattern words to EP6.
  - `usb_flagc` rises at level 384 and `usb_flagb` rises at 512.
  - A 513th write sets `err_overrun`; `rx_words` = 512.
- MODE 0, DRAIN_DIV = 4: stream 1000 correct pattern writes, gated by `usb_flagb`. Result: no error bits set, `rx_words` = 1000.
- MODE 0: corrupt the 10th written word to 0xDEAD. `err_mismatch` sets after that word drains and stays set.
- MODE 1: write 8 words 0x0001..0x0008 to EP6, then read EP2 eight times.
  - The bus returns 0x0001..0x0008 in order and `usb_flaga` falls after the last read.
  - A simultaneous EP6 write and EP2 read at level 3 leaves the level at 3.
- Assert `rst` mid-stream at level 100.
  - `usb_fd` goes high-Z immediately and all counters and errors clear.
  - The first read after release returns PAT_START.
